// File: rtl/target_judge.sv
// ----------------------------------------------------------------------------
// target_judge
//   Arms a random target box, then judges sensor contacts against it:
//   a debounced contact on the target is a hit (sound + score), a contact on
//   another box is a wrong press, and an expired window is a miss. A dead-time
//   gap separates consecutive targets.
//
// Ports
//   CLOCK_50     in   sole clock, rising edge
//   resetn       in   asynchronous active-low reset (release synchronised)
//   start_game   in   game-run level; 0 aborts back to IDLE
//   lfsr_value   in   [2:0] pseudo-random target candidate
//   box_address  in   [2:0] sensor box index, 0 = no contact
//   target_box   out  [2:0] current target (1..6) while target_valid
//   target_valid out  a target is armed
//   hit_pulse    out  one-cycle strobe: target hit
//   wrong_pulse  out  one-cycle strobe: non-target box hit
//   miss_pulse   out  one-cycle strobe: window expired
//   play_sound   out  audio enable, held after a hit
//   hit_count    out  [10:0] hits since game start, saturating
//
// Configuration
//   TARGET_NO_REPEAT_EN  when defined, a new target never equals the previous
//                        one (fallback target is 1, or 2 if previous was 1).
// ----------------------------------------------------------------------------
module target_judge #(
    parameter int WINDOW_CYCLES   = 25000000,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SOUND_CYCLES    = 5000000,
    parameter int GAP_CYCLES      = 12500000
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start_game,
    input  logic [2:0]  lfsr_value,
    input  logic [2:0]  box_address,
    output logic [2:0]  target_box,
    output logic        target_valid,
    output logic        hit_pulse,
    output logic        wrong_pulse,
    output logic        miss_pulse,
    output logic        play_sound,
    output logic [10:0] hit_count
);

    localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SND_W = $clog2(SOUND_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ARMED, HIT_HOLD, GAP} state_t;

    // Reset asserts asynchronously, releases two clock edges later.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t             state;
    logic [2:0]         retry_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [SND_W-1:0]   snd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               sound_reg;

    // Debouncer state
    logic [2:0]         sample;
    logic [DB_W-1:0]    db_cnt;
    logic               accept;
    logic [2:0]         accept_val;

    logic               cand_ok;
    logic [2:0]         fallback;
    logic               load_done;
    logic               debounced_zero;

    always_comb begin
        cand_ok  = (lfsr_value != 3'd0) && (lfsr_value != 3'd7);
        fallback = 3'd1;
`ifdef TARGET_NO_REPEAT_EN
        // target_box still holds the previous target while in LOAD.
        cand_ok  = cand_ok && (lfsr_value != target_box);
        fallback = (target_box == 3'd1) ? 3'd2 : 3'd1;
`endif
        // The 8th consecutive reject forces the fallback target.
        load_done = (state == LOAD) && start_game && (cand_ok || retry_cnt == 3'd7);
    end

    assign debounced_zero = (sample == 3'd0) && (db_cnt == DB_W'(DEBOUNCE_CYCLES));

    // Debounce: accept a value once when it has been seen DEBOUNCE_CYCLES
    // times in a row; the count saturates so it is not accepted again until
    // the input changes.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sample     <= 3'd0;
            db_cnt     <= '0;
            accept     <= 1'b0;
            accept_val <= 3'd0;
        end else begin
            sample <= box_address;
            accept <= 1'b0;
            if (load_done) begin
                db_cnt <= '0;
            end else if (box_address != sample) begin
                db_cnt     <= DB_W'(1);
                accept     <= (DEBOUNCE_CYCLES == 1);
                accept_val <= box_address;
            end else if (db_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
                db_cnt     <= db_cnt + DB_W'(1);
                accept     <= (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));
                accept_val <= box_address;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            retry_cnt    <= 3'd0;
            win_cnt      <= '0;
            snd_cnt      <= '0;
            gap_cnt      <= '0;
            sound_reg    <= 1'b0;
            target_box   <= 3'd0;
            target_valid <= 1'b0;
            hit_pulse    <= 1'b0;
            wrong_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            hit_count    <= 11'd0;
        end else begin
            hit_pulse   <= 1'b0;
            wrong_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            if (state != IDLE && !start_game) begin
                // Abort: everything back to the idle picture, no strobes.
                state        <= IDLE;
                retry_cnt    <= 3'd0;
                win_cnt      <= '0;
                snd_cnt      <= '0;
                gap_cnt      <= '0;
                sound_reg    <= 1'b0;
                target_box   <= 3'd0;
                target_valid <= 1'b0;
                hit_count    <= 11'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_game) begin
                            state     <= LOAD;
                            retry_cnt <= 3'd0;
                            hit_count <= 11'd0;
                        end
                    end
                    LOAD: begin
                        if (load_done) begin
                            target_box   <= cand_ok ? lfsr_value : fallback;
                            target_valid <= 1'b1;
                            win_cnt      <= '0;
                            retry_cnt    <= 3'd0;
                            state        <= ARMED;
                        end else begin
                            retry_cnt <= retry_cnt + 3'd1;
                        end
                    end
                    ARMED: begin
                        // Hit outranks expiry; expiry outranks a wrong press.
                        if (accept && accept_val == target_box) begin
                            hit_pulse    <= 1'b1;
                            if (hit_count != 11'h7FF) hit_count <= hit_count + 11'd1;
                            target_valid <= 1'b0;
                            sound_reg    <= 1'b1;
                            snd_cnt      <= '0;
                            state        <= HIT_HOLD;
                        end else if (win_cnt == WIN_W'(WINDOW_CYCLES - 1)) begin
                            miss_pulse   <= 1'b1;
                            target_valid <= 1'b0;
                            gap_cnt      <= '0;
                            state        <= GAP;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                            if (accept && accept_val != 3'd0) wrong_pulse <= 1'b1;
                        end
                    end
                    HIT_HOLD: begin
                        if (snd_cnt == SND_W'(SOUND_CYCLES - 1)) begin
                            sound_reg <= 1'b0;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end else begin
                            snd_cnt <= snd_cnt + SND_W'(1);
                        end
                    end
                    GAP: begin
                        if (gap_cnt != GAP_W'(GAP_CYCLES - 1)) begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end else if (debounced_zero) begin
                            retry_cnt <= 3'd0;
                            state     <= LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sound must cut out the moment the game is stopped, not one edge later.
    assign play_sound = sound_reg & start_game;

endmodule

// File: tb/tb_target_judge.sv
// ----------------------------------------------------------------------------
// tb_target_judge
//   Directed self-checking bench for target_judge with short timing
//   parameters (window 20, debounce 2, sound 5, gap 4).
// ----------------------------------------------------------------------------
module tb_target_judge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_game;
    logic [2:0]  lfsr_value;
    logic [2:0]  box_address;
    logic [2:0]  target_box;
    logic        target_valid;
    logic        hit_pulse;
    logic        wrong_pulse;
    logic        miss_pulse;
    logic        play_sound;
    logic [10:0] hit_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    target_judge #(
        .WINDOW_CYCLES  (20),
        .DEBOUNCE_CYCLES(2),
        .SOUND_CYCLES   (5),
        .GAP_CYCLES     (4)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start_game  (start_game),
        .lfsr_value  (lfsr_value),
        .box_address (box_address),
        .target_box  (target_box),
        .target_valid(target_valid),
        .hit_pulse   (hit_pulse),
        .wrong_pulse (wrong_pulse),
        .miss_pulse  (miss_pulse),
        .play_sound  (play_sound),
        .hit_count   (hit_count)
    );

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            checks++;
            if ((int'(hit_pulse) + int'(wrong_pulse) + int'(miss_pulse)) > 1) begin
                errors++;
                $display("FAIL pulse_exclusive: hit=%b wrong=%b miss=%b, required at most one",
                         hit_pulse, wrong_pulse, miss_pulse);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        resetn      = 1'b0;
        start_game  = 1'b0;
        lfsr_value  = 3'd0;
        box_address = 3'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Start the game and return the number of cycles until target_valid (-1 on timeout).
    task automatic arm(input logic [2:0] lfsr, output int lat);
        lfsr_value = lfsr;
        start_game = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (target_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({target_box, target_valid, hit_pulse, wrong_pulse, miss_pulse, play_sound, hit_count} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got box=%0d valid=%b h/w/m=%b%b%b snd=%b cnt=%0d, required all 0",
                     target_box, target_valid, hit_pulse, wrong_pulse, miss_pulse, play_sound, hit_count);
        end
        $display("reset: outputs idle");
    endtask

    task automatic test_hit;
        int lat, hits, first, snd, others;
        do_reset();
        arm(3'd3, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL hit_arm_latency: got %0d, required 2", lat); end
        checks++;
        if (target_box !== 3'd3) begin errors++; $display("FAIL hit_target: got %0d, required 3", target_box); end
        box_address = 3'd3;
        hits = 0; first = -1; snd = 0; others = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 2) box_address = 3'd0;
            if (hit_pulse) begin hits++; if (first < 0) first = i; end
            if (play_sound) snd++;
            if (wrong_pulse || miss_pulse) others++;
        end
        checks++;
        if (hits !== 1) begin errors++; $display("FAIL hit_pulse_count: got %0d, required 1", hits); end
        checks++;
        if (first !== 3) begin errors++; $display("FAIL hit_latency: got %0d, required 3", first); end
        checks++;
        if (snd !== 5) begin errors++; $display("FAIL sound_cycles: got %0d, required 5", snd); end
        checks++;
        if (hit_count !== 11'd1) begin errors++; $display("FAIL hit_count: got %0d, required 1", hit_count); end
        checks++;
        if (others !== 0) begin errors++; $display("FAIL hit_other_pulses: got %0d, required 0", others); end
        $display("hit: latency=%0d pulses=%0d sound=%0d count=%0d", first, hits, snd, hit_count);
    endtask

    task automatic test_wrong;
        int lat, wrongs, hits;
        do_reset();
        arm(3'd3, lat);
        box_address = 3'd5;
        wrongs = 0; hits = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) box_address = 3'd0;
            if (wrong_pulse) wrongs++;
            if (hit_pulse) hits++;
        end
        checks++;
        if (wrongs !== 1) begin errors++; $display("FAIL wrong_count: got %0d, required 1", wrongs); end
        checks++;
        if (hits !== 0 || hit_count !== 11'd0) begin
            errors++; $display("FAIL wrong_no_hit: got hits=%0d count=%0d, required 0/0", hits, hit_count);
        end
        checks++;
        if (target_valid !== 1'b1) begin errors++; $display("FAIL wrong_stays_armed: got %b, required 1", target_valid); end
        $display("wrong: pulses=%0d count=%0d", wrongs, hit_count);
    endtask

    task automatic test_miss;
        int lat, at, relat, extra;
        do_reset();
        arm(3'd2, lat);
        at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (miss_pulse) begin at = i; break; end
        end
        checks++;
        if (at !== 20) begin errors++; $display("FAIL miss_latency: got %0d, required 20", at); end
        checks++;
        if (target_valid !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b, required 0", target_valid); end
        relat = -1; extra = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (miss_pulse) extra++;
            if (target_valid) begin relat = i; break; end
        end
        checks++;
        if (relat !== 5) begin errors++; $display("FAIL gap_rearm: got %0d, required 5", relat); end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL miss_single: got %0d extra, required 0", extra); end
        $display("miss: after %0d cycles, rearm after %0d", at, relat);
    endtask

    task automatic test_retry;
        int lat;
        do_reset();
        arm(3'd7, lat);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL retry_latency: got %0d, required 9", lat); end
        checks++;
        if (target_box !== 3'd1) begin errors++; $display("FAIL retry_target: got %0d, required 1", target_box); end
        $display("retry: latency=%0d target=%0d", lat, target_box);
    endtask

    task automatic test_repeat;
        int lat;
        logic dropped;
        logic [2:0] exp_box;
`ifdef TARGET_NO_REPEAT_EN
        exp_box = 3'd1;
`else
        exp_box = 3'd4;
`endif
        do_reset();
        arm(3'd4, lat);
        box_address = 3'd4;
        repeat (2) @(negedge clk);
        box_address = 3'd0;
        dropped = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (!target_valid) dropped = 1'b1;
            if (dropped && target_valid) begin lat = i; break; end
        end
        checks++;
        if (lat < 0) begin errors++; $display("FAIL repeat_rearm: no second target within budget"); end
        checks++;
        if (target_box !== exp_box) begin
            errors++; $display("FAIL repeat_target: got %0d, required %0d", target_box, exp_box);
        end
        checks++;
        if (hit_count !== 11'd1) begin errors++; $display("FAIL repeat_count: got %0d, required 1", hit_count); end
        $display("repeat: second target=%0d", target_box);
    endtask

    task automatic test_reset_midgame;
        int lat;
        do_reset();
        arm(3'd3, lat);
        box_address = 3'd3;
        repeat (2) @(negedge clk);
        box_address = 3'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (play_sound !== 1'b1) begin errors++; $display("FAIL midgame_precond: sound=%b, required 1", play_sound); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({play_sound, target_valid, hit_count, target_box, hit_pulse, wrong_pulse, miss_pulse} !== 19'd0) begin
            errors++;
            $display("FAIL midgame_reset: got snd=%b valid=%b cnt=%0d box=%0d, required all 0",
                     play_sound, target_valid, hit_count, target_box);
        end
        start_game = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        $display("reset_midgame: outputs cleared asynchronously");
    endtask

    task automatic test_abort;
        int lat;
        do_reset();
        arm(3'd5, lat);
        box_address = 3'd5;
        repeat (2) @(negedge clk);
        // Hit would be issued on the next edge; abort instead.
        start_game  = 1'b0;
        box_address = 3'd0;
        @(negedge clk);
        checks++;
        if (hit_pulse !== 1'b0 || hit_count !== 11'd0) begin
            errors++; $display("FAIL abort_no_pulse: got hit=%b cnt=%0d, required 0/0", hit_pulse, hit_count);
        end
        checks++;
        if (target_valid !== 1'b0 || target_box !== 3'd0) begin
            errors++; $display("FAIL abort_idle: got valid=%b box=%0d, required 0/0", target_valid, target_box);
        end
        // Sound must drop without waiting for a clock edge.
        arm(3'd5, lat);
        box_address = 3'd5;
        repeat (2) @(negedge clk);
        box_address = 3'd0;
        @(negedge clk);
        checks++;
        if (play_sound !== 1'b1) begin errors++; $display("FAIL abort_sound_precond: got %b, required 1", play_sound); end
        #2 start_game = 1'b0;
        #1;
        checks++;
        if (play_sound !== 1'b0) begin errors++; $display("FAIL abort_sound_drop: got %b, required 0", play_sound); end
        @(negedge clk);
        checks++;
        if (hit_count !== 11'd0 || target_valid !== 1'b0) begin
            errors++; $display("FAIL abort_sound_idle: got cnt=%0d valid=%b, required 0/0", hit_count, target_valid);
        end
        $display("abort: idle with no pulse, sound dropped");
    endtask

    initial begin
        test_reset();
        test_hit();
        test_wrong();
        test_miss();
        test_retry();
        test_repeat();
        test_reset_midgame();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
